// File: rtl/booth_mul_sched_pkg.sv
// Shared types and constants for the multiplier scheduler: FSM state encoding,
// default operand/product widths and the requester-id width helper.
package booth_mul_sched_pkg;

    localparam int unsigned MulW  = 8;
    localparam int unsigned ProdW = 2 * MulW;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait,
        StResp
    } state_e;

    // A single requester still needs a 1-bit id/pointer field.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/booth_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the pointer,
// wrapping from NREQ-1 back to 0. Produces a one-hot grant and its encoded index.
module booth_mul_scheduler_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_cand = IDW'((int'(i_ptr) + k) % int'(NREQ));
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Shares one multi-cycle signed multiplier among NREQ valid/ready requesters.
// Optional WAIT timeout abort is enabled by defining MUL_SCHED_TIMEOUT_EN.
module booth_mul_scheduler
    import booth_mul_sched_pkg::*;
#(
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned W       = MulW,
    parameter  int unsigned TIMEOUT = 40,
    localparam int unsigned IDW     = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*W-1:0] i_req_a,
    input  logic [NREQ*W-1:0] i_req_b,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [IDW-1:0]    o_resp_id,
    output logic [2*W-1:0]    o_resp_p,
    output logic              o_resp_err,
    output logic              o_mul_load,
    output logic [W-1:0]      o_mul_a,
    output logic [W-1:0]      o_mul_b,
    input  logic              i_mul_rdy,
    input  logic [2*W-1:0]    i_mul_p,
    output logic              o_busy
);

    state_e         r_state, w_state_d;
    logic [W-1:0]   r_a, r_b, w_sel_a, w_sel_b;
    logic [IDW-1:0] r_id, r_ptr, w_idx, w_ptr_next;
    logic [2*W-1:0] r_p;
    logic           r_first;
    logic [NREQ-1:0] w_gnt;
    logic           w_any, w_done, w_timeout;

    booth_mul_scheduler_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_idx == IDW'(i)) begin
                w_sel_a = i_req_a[i*W +: W];
                w_sel_b = i_req_b[i*W +: W];
            end
        end
    end

    // First WAIT cycle may still see rdy left over from the previous operation.
    assign w_done     = (r_state == StWait) && !r_first && i_mul_rdy;
    assign w_ptr_next = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

`ifdef MUL_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] r_cnt;
    logic            r_err;

    assign w_timeout  = (r_state == StWait) && !w_done && (r_cnt == CntW'(TIMEOUT - 1));
    assign o_resp_err = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == StLoad) begin
                r_cnt <= '0;
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done || w_timeout) begin
                r_err <= w_timeout;
            end
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign o_resp_err = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_any) w_state_d = StLoad;
            StLoad:  w_state_d = StWait;
            StWait:  if (w_done || w_timeout) w_state_d = StResp;
            StResp:  if (i_resp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_p     <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && w_any) begin
                r_a  <= w_sel_a;
                r_b  <= w_sel_b;
                r_id <= w_idx;
            end
            if (r_state == StLoad) begin
                r_first <= 1'b1;
            end else if (r_state == StWait) begin
                r_first <= 1'b0;
            end
            if (w_done || w_timeout) begin
                r_p <= w_timeout ? '0 : i_mul_p;
            end
            if (r_state == StResp && i_resp_ready) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // Gate with reset so a requester held valid through reset sees no accept.
    assign o_req_ready  = (r_state == StIdle && !reset) ? w_gnt : '0;
    assign o_mul_load   = (r_state == StLoad);
    assign o_busy       = (r_state != StIdle);
    assign o_resp_valid = (r_state == StResp);
    assign o_resp_id    = r_id;
    assign o_resp_p     = r_p;
    assign o_mul_a      = r_a;
    assign o_mul_b      = r_b;

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Scoreboard bench for booth_mul_scheduler with a behavioural multi-cycle multiplier.
// Define MUL_SCHED_TIMEOUT_EN to also exercise the WAIT timeout abort.
module tb_booth_mul_scheduler;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 40;
    localparam int LAT     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              resp_valid, resp_ready, resp_err;
    logic [1:0]        resp_id;
    logic [2*W-1:0]    resp_p;
    logic              mul_load, busy;
    logic [W-1:0]      mul_a, mul_b;
    logic              mul_rdy = 1'b0;
    logic [2*W-1:0]    mul_p = '0;

    always #5 clk = ~clk;

    booth_mul_scheduler #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_id    (resp_id),
        .o_resp_p     (resp_p),
        .o_resp_err   (resp_err),
        .o_mul_load   (mul_load),
        .o_mul_a      (mul_a),
        .o_mul_b      (mul_b),
        .i_mul_rdy    (mul_rdy),
        .i_mul_p      (mul_p),
        .o_busy       (busy)
    );

    // Multiplier model: rdy stays stale for one cycle after load, then drops,
    // and rises LAT edges after load unless stuck.
    logic              m_busy = 1'b0;
    logic              stuck  = 1'b0;
    int                m_cnt  = 0;
    logic signed [7:0] ma, mb;

    always @(posedge clk) begin
        if (mul_load) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            ma     <= mul_a;
            mb     <= mul_b;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 0) mul_rdy <= 1'b0;
            if (m_cnt == LAT - 1 && !stuck) begin
                mul_rdy <= 1'b1;
                mul_p   <= ma * mb;
                m_busy  <= 1'b0;
            end
        end
    end

    typedef struct packed {
        logic        err;
        logic [1:0]  id;
        logic [15:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   total = 0;
    int   bad = 0;
    int   load_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: sampled on the falling edge, inputs are driven just after the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got id=%0d p=%h want none", resp_id, resp_p);
            end else begin
                e = exp_q.pop_front();
                check("resp_id", 32'(resp_id), 32'(e.id));
                check("resp_p", 32'(resp_p), 32'(e.p));
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
        if (|req_ready) begin
            check("ready_onehot", $countones(req_ready), 1);
            check("ready_only_idle", 32'(busy), 0);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
        end
        if (mul_load) load_cnt++;
    end

    task automatic push_exp(input int id, input logic [15:0] p, input logic err);
        exp_t e;
        e.err = err;
        e.id  = 2'(id);
        e.p   = p;
        exp_q.push_back(e);
    endtask

    // Returns one cycle after the grant edge, i.e. while the DUT is in LOAD.
    task automatic wait_grant(input int id);
        int n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[id]) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: got no req_ready[%0d] want grant", id);
            void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] p, input logic err);
        @(posedge clk);
        #1;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
        push_exp(id, p, err);
        wait_grant(id);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_resp_id"}, 32'(resp_id), 0);
        check({tag, "_resp_p"}, 32'(resp_p), 0);
        check({tag, "_resp_err"}, 32'(resp_err), 0);
        check({tag, "_mul_load"}, 32'(mul_load), 0);
        check({tag, "_mul_ab"}, {16'h0, mul_a, mul_b}, 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic op, latency and single load pulse.
        issue(0, 8'd3, 8'd5, 16'h000F, 1'b0);
        check("load_pulse_high", 32'(mul_load), 1);
        check("load_ab", {16'h0, mul_a, mul_b}, 32'h0305);
        k = 1;
        while (!resp_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k, LAT + 3);
        drain();
        check("load_pulses", load_cnt, 1);

        // Signed corners; model holds stale rdy/product from the previous op.
        issue(2, 8'hFD, 8'h07, 16'hFFEB, 1'b0);
        drain();
        issue(2, 8'h80, 8'h80, 16'h4000, 1'b0);
        drain();

        // All requesters valid through reset: grants 0,1,2,3,0.
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_a     = {8'hFF, 8'd127, 8'd12, 8'd3};
        req_b     = {8'hFF, 8'd127, 8'hFE, 8'd5};
        req_valid = '1;
        #1;
        check("rst_valid_ready", 32'(req_ready), 0);
        grant_log.delete();
        push_exp(0, 16'h000F, 1'b0);
        push_exp(1, 16'hFFE8, 1'b0);
        push_exp(2, 16'h3F01, 1'b0);
        push_exp(3, 16'h0001, 1'b0);
        push_exp(0, 16'h000F, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;
        while (grant_log.size() < 5 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        req_valid = '0;
        drain();
        check("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) check("rr_order", grant_log[i], i % 4);
        end

        // Response back-pressure: held stable, no new grant while stalled.
        resp_ready = 1'b0;
        issue(1, 8'd100, 8'd3, 16'h012C, 1'b0);
        k = 0;
        while (!resp_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        req_a[3*W +: W] = 8'h9C;
        req_b[3*W +: W] = 8'd2;
        req_valid[3]    = 1'b1;
        push_exp(3, 16'hFF38, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 1);
            check("stall_id_p", {14'h0, resp_id, resp_p}, {14'h0, 2'd1, 16'h012C});
            check("stall_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_grant(3);
        drain();

        // Reset during WAIT abandons the op; the next request completes.
        issue(0, 8'd7, 8'd8, 16'h0038, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check_all_zero("midop_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(1, 8'd2, 8'h80, 16'hFF00, 1'b0);
        drain();
        issue(2, 8'd5, 8'd5, 16'h0019, 1'b0);
        drain();

`ifdef MUL_SCHED_TIMEOUT_EN
        stuck = 1'b1;
        issue(2, 8'd5, 8'd5, 16'h0000, 1'b1);
        k = 0;
        while (!resp_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("timeout_cycles", k, TIMEOUT + 1);
        drain();
        stuck = 1'b0;
        issue(3, 8'd64, 8'hFE, 16'hFF80, 1'b0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
